// File: rtl/pe_packet_out_pkg.sv
// rtl/pe_packet_out_pkg.sv - shared network packet widths, field offsets and packet typedef
//
// Purpose: one place for the packet layout {x, y, message} (X in the MSBs),
// used by the outbound path, the router and the inbound path.
// Ports: none (package).
package pe_packet_out_pkg;

  localparam int COORD_BITS_DEF   = 1;
  localparam int MESSAGE_BITS_DEF = 32;
  localparam int PACKET_BITS_DEF  = 2 * COORD_BITS_DEF + MESSAGE_BITS_DEF;

  // Field offsets for the default layout; message sits at bit 0.
  localparam int MSG_LSB_DEF = 0;
  localparam int Y_LSB_DEF   = MESSAGE_BITS_DEF;
  localparam int X_LSB_DEF   = MESSAGE_BITS_DEF + COORD_BITS_DEF;

  typedef struct packed {
    logic [COORD_BITS_DEF-1:0]   x;
    logic [COORD_BITS_DEF-1:0]   y;
    logic [MESSAGE_BITS_DEF-1:0] msg;
  } packet_t;

  function automatic int packet_bits(input int coord_bits, input int message_bits);
    return 2 * coord_bits + message_bits;
  endfunction

endpackage

// File: rtl/pe_packet_fifo.sv
// rtl/pe_packet_fifo.sv - show-ahead packet FIFO with registered head
//
// Purpose: DEPTH-entry FIFO whose head word and valid are driven from flops.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_valid, wr_data   push request and data (ignored when full without a pop)
//   rd_valid, rd_data   registered head valid / head word
//   rd_ready            pop when rd_valid && rd_ready
//   full, count         registered occupancy flags
module pe_packet_fifo
  import pe_packet_out_pkg::*;
#(
  parameter int WIDTH = PACKET_BITS_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       rd_ready,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count_n, remain;
  logic [WIDTH-1:0] head_n;
  logic             push, pop;

  assign pop      = rd_valid & rd_ready;
  assign push     = wr_valid & (~full | pop);
  assign rd_ptr_n = rd_ptr + AW'(pop);   // power-of-two depth: wraps naturally
  assign remain   = count - CW'(pop);
  assign count_n  = remain + CW'(push);

  // Next head: when the only surviving entry is the one being pushed now,
  // bypass the write data; otherwise the entry at the advanced read pointer
  // is already in memory. An empty FIFO simply holds the old word.
  always_comb begin
    head_n = rd_data;
    if (count_n != '0) begin
      if (remain == '0) head_n = wr_data;
      else              head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      full     <= (count_n == CW'(DEPTH));
      rd_valid <= (count_n != '0);
      rd_data  <= head_n;
    end
  end

endmodule

// File: rtl/pe_packet_out.sv
// rtl/pe_packet_out.sv - PE outbound packet staging, commit/drop logic and injection FIFO
//
// Purpose: stages X/Y/message from write strobes, commits {x, y, msg} into a
// show-ahead FIFO on packet_complete, drops commits that find the FIFO full.
// Optional macro: PE_PACKET_OUT_DROP_COUNT_EN enables the drop counter;
// without it drop_count is tied to 0 (drops still happen).
// Ports:
//   clk, reset                           clock, asynchronous active-high reset
//   x_coord_in/_valid, y_coord_in/_valid destination coordinate strobes
//   message_in/_valid                    payload strobe
//   packet_complete                      commit strobe
//   packet_out/_valid/_ready             FIFO head towards the router
//   fifo_full, fifo_count, drop_count    status
module pe_packet_out
  import pe_packet_out_pkg::*;
#(
  parameter int COORD_BITS   = COORD_BITS_DEF,
  parameter int MESSAGE_BITS = MESSAGE_BITS_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [COORD_BITS-1:0]               x_coord_in,
  input  logic                                x_coord_in_valid,
  input  logic [COORD_BITS-1:0]               y_coord_in,
  input  logic                                y_coord_in_valid,
  input  logic [MESSAGE_BITS-1:0]             message_in,
  input  logic                                message_in_valid,
  input  logic                                packet_complete,
  output logic [2*COORD_BITS+MESSAGE_BITS-1:0] packet_out,
  output logic                                packet_out_valid,
  input  logic                                packet_out_ready,
  output logic                                fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic [15:0]                         drop_count
);

  localparam int PW = packet_bits(COORD_BITS, MESSAGE_BITS);

  logic [COORD_BITS-1:0]   stage_x, stage_y;
  logic [MESSAGE_BITS-1:0] stage_msg;
  logic                    msg_staged;
  logic [COORD_BITS-1:0]   commit_x, commit_y;
  logic [MESSAGE_BITS-1:0] commit_msg;
  logic                    commit;
  logic [PW-1:0]           commit_pkt;

  // Same-cycle strobes bypass the staging registers into the committed packet.
  assign commit_x   = x_coord_in_valid ? x_coord_in : stage_x;
  assign commit_y   = y_coord_in_valid ? y_coord_in : stage_y;
  assign commit_msg = message_in_valid ? message_in : stage_msg;
  assign commit     = packet_complete & (msg_staged | message_in_valid);
  assign commit_pkt = {commit_x, commit_y, commit_msg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_x    <= '0;
      stage_y    <= '0;
      stage_msg  <= '0;
      msg_staged <= 1'b0;
    end else begin
      if (x_coord_in_valid) stage_x   <= x_coord_in;
      if (y_coord_in_valid) stage_y   <= y_coord_in;
      if (message_in_valid) stage_msg <= message_in;
      // A commit consumes the message, including one arriving that same cycle.
      if (commit)                msg_staged <= 1'b0;
      else if (message_in_valid) msg_staged <= 1'b1;
    end
  end

  // The FIFO itself rejects a push when full unless a pop frees the slot.
  pe_packet_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (commit),
    .wr_data  (commit_pkt),
    .rd_valid (packet_out_valid),
    .rd_data  (packet_out),
    .rd_ready (packet_out_ready),
    .full     (fifo_full),
    .count    (fifo_count)
  );

`ifdef PE_PACKET_OUT_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = commit & fifo_full & ~(packet_out_valid & packet_out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: doc/pe_packet_out.md
PE_PACKET_OUT -- requirements
Module: pe_packet_out

Interface
REQ-001 Parameter COORD_BITS, default 1: width of each destination coordinate.
REQ-002 Parameter MESSAGE_BITS, default 32: payload width.
REQ-003 Parameter FIFO_DEPTH, default 4: packet FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 x_coord_in  in  COORD_BITS  destination X; sampled when x_coord_in_valid is high.
REQ-007 x_coord_in_valid  in  1  one-cycle write strobe for X.
REQ-008 y_coord_in  in  COORD_BITS  destination Y; sampled when y_coord_in_valid is high.
REQ-009 y_coord_in_valid  in  1  one-cycle write strobe for Y.
REQ-010 message_in  in  MESSAGE_BITS  payload word; sampled when message_in_valid is high.
REQ-011 message_in_valid  in  1  one-cycle write strobe for the payload.
REQ-012 packet_complete  in  1  one-cycle commit strobe for the staged packet.
REQ-013 packet_out  out  2*COORD_BITS+MESSAGE_BITS  FIFO head, packed as {x, y, message} with X in the MSBs.
REQ-014 packet_out_valid  out  1  FIFO non-empty.
REQ-015 packet_out_ready  in  1  router injection grant; a pop occurs when valid and ready are both high.
REQ-016 fifo_full  out  1  occupancy equals FIFO_DEPTH.
REQ-017 fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
REQ-018 drop_count  out  16  saturating count of dropped commits.

Function
REQ-019 Staging registers (stage_x, stage_y, stage_msg) and a msg_staged flag SHALL load from their strobes.
- Coordinates persist across packets until rewritten.
REQ-020 A commit is packet_complete high while msg_staged is high, or while message_in_valid is high in the same cycle.
- Strobes that are high in the commit cycle SHALL bypass into the committed packet.
REQ-021 packet_complete with no message staged and no bypass SHALL be ignored: no push, no drop.
REQ-022 A commit SHALL push {x, y, msg} into the FIFO and clear msg_staged.
- If message_in_valid is high in the same cycle, msg_staged stays cleared (the word was consumed by the commit).
REQ-023 Commit latency: commit at cycle N -> packet_out_valid high at N+1 if the FIFO was empty.
REQ-024 The FIFO SHALL be show-ahead: packet_out equals the head entry whenever packet_out_valid is high.
REQ-025 packet_out and packet_out_valid SHALL be registered and driven directly from flops.
REQ-026 A commit while the FIFO is full and no pop occurs that cycle SHALL be dropped.
- The packet is discarded, msg_staged is cleared, and drop_count increments, saturating at 16'hFFFF.
REQ-027 A commit while full with a simultaneous pop SHALL be accepted; occupancy stays at FIFO_DEPTH.
REQ-028 Simultaneous push and pop at any occupancy SHALL leave fifo_count unchanged.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 packet_out SHALL hold its value while packet_out_valid is high and packet_out_ready is low.

Reset
REQ-031 While reset is high, the following SHALL be cleared asynchronously:
- FIFO pointers, fifo_count, drop_count, msg_staged, stage_x, stage_y and stage_msg all reset to 0.
- packet_out_valid and fifo_full reset to 0; packet_out resets to 0.
REQ-032 Reset mid-operation SHALL discard all staged and queued packets; no partial packet is emitted after release.

Configuration
REQ-033 Macro PE_PACKET_OUT_DROP_COUNT_EN SHALL control the drop counter.
- Defined: drop_count behaves per REQ-026.
- Undefined: drop_count is tied to 0, the counter flops are removed, and drops still occur.

Structure
REQ-034 The shared network package SHALL hold the packet field widths, the packed-field offsets and a packet typedef.
- The same definitions are reused by the router and the inbound path.
REQ-035 The FIFO SHALL be the sub-module pe_packet_fifo (show-ahead, parameterised width and depth, count and full outputs).
- pe_packet_out contains the staging and commit/drop logic.

Verification
REQ-036 Scenario 1: write x=1, y=0, msg=32'hDEADBEEF, then complete, with ready=1.
- Required: packet_out={1'b1, 1'b0, 32'hDEADBEEF} with valid at commit+1, popped next cycle, fifo_count returns to 0.
REQ-037 Scenario 2: msg=32'h5 and complete asserted in the same cycle, coordinates left from the previous packet.
- Required: the packet carries 32'h5 and the previous coordinates.
REQ-038 Scenario 3: ready=0, commit 5 packets, messages 1..5, FIFO_DEPTH=4.
- Required: fifo_full=1, drop_count=1, then with ready=1 the outputs are 1, 2, 3, 4 in order.
REQ-039 Scenario 4: FIFO full, commit and pop in the same cycle.
- Required: no drop, fifo_count stays 4, and the new packet is the last entry out.
REQ-040 Scenario 5: complete with no message staged.
- Required: fifo_count and drop_count unchanged.
REQ-041 Scenario 6: assert reset with 3 queued packets and a staged message.
- Required: valid=0 and count=0 immediately; after release a bare complete pushes nothing.
